// File: rtl/unified_mem_arbiter.sv
// ---------------------------------------------------------------------------
// unified_mem_arbiter
//
// Shares one external memory port between instruction fetch (I) and the
// memory stage (D). D has fixed priority over I, but after MAX_D_STREAK
// back-to-back D grants with I waiting, I is forced to win once. Only one
// memory transaction is outstanding at a time. Completion is signalled to
// each requester with a one-cycle registered *_valid pulse.
//
// State table:
//   state   | meaning
//   IDLE    | no transaction; arbitrate (blocked during a valid pulse cycle)
//   REQ     | mem_req driven with latched fields, waiting for mem_gnt
//   RESP    | request accepted, waiting for mem_rvalid
//
// Ports:
//   clk, reset                      core clock, synchronous active-high reset
//   i_req, i_addr                   fetch request (held until i_valid)
//   i_rdata, i_valid                fetch data and completion pulse
//   d_req, d_addr, d_wdata, d_we    data request (held until d_valid)
//   d_rdata, d_valid                load data and completion pulse
//   mem_req, mem_gnt                request/accept handshake to memory
//   mem_address, mem_write_data,
//   mem_write_enable                registered fields of the transaction
//   mem_rvalid, mem_read_data       memory response
//   err_spurious                    sticky: response seen with nothing outstanding
// ---------------------------------------------------------------------------
module unified_mem_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned STREAK_W     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_valid,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [3:0]  d_we,
    output logic [31:0] d_rdata,
    output logic        d_valid,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_write_enable,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_read_data,
    output logic        err_spurious
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    state_t              state, state_nxt;
    logic                owner_d, owner_d_nxt;   // 1: D owns the transaction
    logic [STREAK_W-1:0] streak, streak_nxt;
    logic                grant;
    logic                grant_d;
    logic                complete;
    logic                spurious;

    always_comb begin
        state_nxt   = state;
        owner_d_nxt = owner_d;
        streak_nxt  = streak;
        grant       = 1'b0;
        grant_d     = 1'b0;
        complete    = 1'b0;
        spurious    = 1'b0;
        mem_req     = 1'b0;

        case (state)
            ST_IDLE: begin
                if (mem_rvalid) begin
                    spurious = 1'b1;
                end
                // The valid-pulse cycle is a dead cycle: the requester that was
                // just served may still be holding its request.
                if (!(i_valid || d_valid)) begin
                    if (d_req && i_req) begin
                        grant = 1'b1;
                        if (streak < STREAK_MAX) begin
                            grant_d    = 1'b1;
                            streak_nxt = streak + 1'b1;
                        end else begin
                            grant_d    = 1'b0;
                            streak_nxt = '0;
                        end
                    end else if (d_req) begin
                        grant      = 1'b1;
                        grant_d    = 1'b1;
                        streak_nxt = '0;
                    end else if (i_req) begin
                        grant      = 1'b1;
                        grant_d    = 1'b0;
                        streak_nxt = '0;
                    end else begin
                        streak_nxt = '0;
                    end
                    if (grant) begin
                        state_nxt   = ST_REQ;
                        owner_d_nxt = grant_d;
                    end
                end
            end

            ST_REQ: begin
                mem_req = 1'b1;
                if (mem_gnt) begin
                    // Grant and response in the same cycle completes at once.
                    if (mem_rvalid) begin
                        complete  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_RESP;
                    end
                end else if (mem_rvalid) begin
                    spurious = 1'b1;
                end
            end

            ST_RESP: begin
                if (mem_rvalid) begin
                    complete  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            owner_d          <= 1'b0;
            streak           <= '0;
            mem_address      <= '0;
            mem_write_data   <= '0;
            mem_write_enable <= '0;
            i_valid          <= 1'b0;
            d_valid          <= 1'b0;
            i_rdata          <= '0;
            d_rdata          <= '0;
            err_spurious     <= 1'b0;
        end else begin
            state   <= state_nxt;
            owner_d <= owner_d_nxt;
            streak  <= streak_nxt;
            i_valid <= complete && !owner_d;
            d_valid <= complete && owner_d;

            if (complete) begin
                if (owner_d) begin
                    d_rdata <= mem_read_data;
                end else begin
                    i_rdata <= mem_read_data;
                end
            end

            if (grant) begin
                if (grant_d) begin
                    mem_address      <= d_addr;
                    mem_write_data   <= d_wdata;
                    mem_write_enable <= d_we;
                end else begin
                    mem_address      <= i_addr;
                    mem_write_data   <= '0;
                    mem_write_enable <= '0;
                end
            end

            if (spurious) begin
                err_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_we;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_enable;
    logic        mem_rvalid;
    logic [31:0] mem_read_data;
    logic        err_spurious;

    unified_mem_arbiter #(.MAX_D_STREAK(4), .STREAK_W(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_req            (i_req),
        .i_addr           (i_addr),
        .i_rdata          (i_rdata),
        .i_valid          (i_valid),
        .d_req            (d_req),
        .d_addr           (d_addr),
        .d_wdata          (d_wdata),
        .d_we             (d_we),
        .d_rdata          (d_rdata),
        .d_valid          (d_valid),
        .mem_req          (mem_req),
        .mem_gnt          (mem_gnt),
        .mem_address      (mem_address),
        .mem_write_data   (mem_write_data),
        .mem_write_enable (mem_write_enable),
        .mem_rvalid       (mem_rvalid),
        .mem_read_data    (mem_read_data),
        .err_spurious     (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
        bit          chk_wdata;
    } mem_exp_t;

    typedef struct {
        bit          is_d;
        logic [31:0] data;
    } rsp_exp_t;

    mem_exp_t mem_q[$];
    rsp_exp_t rsp_q[$];

    int checks = 0;
    int passes = 0;

    int gnt_delay = 0;
    int rsp_delay = 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic expect_i(input logic [31:0] addr, input logic [31:0] data);
        mem_exp_t m;
        rsp_exp_t r;
        m.addr = addr; m.wdata = '0; m.we = 4'h0; m.chk_wdata = 1'b0;
        r.is_d = 1'b0; r.data = data;
        mem_q.push_back(m);
        rsp_q.push_back(r);
    endtask

    task automatic expect_d(input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] we, input logic [31:0] data);
        mem_exp_t m;
        rsp_exp_t r;
        m.addr = addr; m.wdata = wdata; m.we = we; m.chk_wdata = (we != 4'h0);
        r.is_d = 1'b1; r.data = data;
        mem_q.push_back(m);
        rsp_q.push_back(r);
    endtask

    // Counts rising edges from the call until the requested valid is seen.
    task automatic wait_valid(input bit is_d, output int lat);
        lat = 0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (is_d ? d_valid : i_valid) return;
        end
        checks++;
        $display("FAIL wait_valid_%s: no valid pulse within 60 cycles", is_d ? "d" : "i");
    endtask

    // Memory responder: grants after gnt_delay stall cycles, responds
    // rsp_delay cycles after the grant (0 = same cycle as the grant).
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'hDEAD_BEEF;
            32'h0000_0400: return 32'h0000_00AA;
            default:       return a ^ 32'hCAFE_0000;
        endcase
    endfunction

    initial begin
        int          m_phase;
        int          m_cnt;
        logic [31:0] m_data;
        m_phase = 0;
        m_cnt = 0;
        m_data = '0;
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        mem_read_data = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt = 1'b0;
            mem_rvalid = 1'b0;
            if (m_phase == 0 && mem_req) begin
                m_phase = 1;
                m_cnt = gnt_delay;
            end
            if (m_phase == 1) begin
                if (m_cnt == 0) begin
                    mem_gnt = 1'b1;
                    m_data = mem_data(mem_address);
                    if (rsp_delay == 0) begin
                        mem_rvalid = 1'b1;
                        mem_read_data = m_data;
                        m_phase = 0;
                    end else begin
                        m_phase = 2;
                        m_cnt = rsp_delay - 1;
                    end
                end else begin
                    m_cnt--;
                end
            end else if (m_phase == 2) begin
                if (m_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_read_data = m_data;
                    m_phase = 0;
                end else begin
                    m_cnt--;
                end
            end
        end
    end

    // Monitor: checks memory-side fields at each accepted request and
    // response data/ownership at each valid pulse, in issue order.
    initial begin
        mem_exp_t m;
        rsp_exp_t r;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (mem_req && mem_gnt) begin
                    if (mem_q.size() == 0) begin
                        checks++;
                        $display("FAIL mem_unexpected: request 0x%08h accepted, none expected", mem_address);
                    end else begin
                        m = mem_q.pop_front();
                        check("mem_address", mem_address, m.addr);
                        check("mem_write_enable", 32'(mem_write_enable), 32'(m.we));
                        if (m.chk_wdata) check("mem_write_data", mem_write_data, m.wdata);
                    end
                end
                if (i_valid || d_valid) begin
                    if (rsp_q.size() == 0) begin
                        checks++;
                        $display("FAIL rsp_unexpected: i_valid=%0b d_valid=%0b, none expected", i_valid, d_valid);
                    end else begin
                        r = rsp_q.pop_front();
                        check("rsp_owner {i_valid,d_valid}", 32'({i_valid, d_valid}), r.is_d ? 32'h1 : 32'h2);
                        check("rsp_rdata", r.is_d ? d_rdata : i_rdata, r.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        reset = 1'b1;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_addr = '0; d_wdata = '0; d_we = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("reset_ctrl {mem_req,i_valid,d_valid,err}", 32'({mem_req, i_valid, d_valid, err_spurious}), 32'h0);
        check("reset_mem_write_enable", 32'(mem_write_enable), 32'h0);
        check("reset_i_rdata", i_rdata, 32'h0);
        check("reset_d_rdata", d_rdata, 32'h0);

        // 1: I only, grant immediate, response one cycle later
        @(posedge clk); #1;
        gnt_delay = 0; rsp_delay = 1;
        expect_i(32'h100, 32'hDEAD_BEEF);
        i_addr = 32'h100; i_req = 1'b1;
        wait_valid(1'b0, lat);
        check("t1_latency", 32'(lat), 32'd3);
        check("t1_we_after", 32'(mem_write_enable), 32'h0);
        @(posedge clk); #1;
        i_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 2: both request together with streak 0: store D first, then I
        expect_d(32'h2000, 32'h1234_5678, 4'hF, 32'hCAFE_2000);
        expect_i(32'h104, 32'hCAFE_0104);
        d_addr = 32'h2000; d_wdata = 32'h1234_5678; d_we = 4'hF; d_req = 1'b1;
        i_addr = 32'h104; i_req = 1'b1;
        wait_valid(1'b1, lat);
        @(posedge clk); #1;
        d_req = 1'b0;
        wait_valid(1'b0, lat);
        @(posedge clk); #1;
        i_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 3: starvation limit: four D grants, then I, then D again
        for (int k = 0; k < 4; k++) expect_d(32'h2010, 32'hA5A5_0F0F, 4'b0011, 32'hCAFE_2010);
        expect_i(32'h108, 32'hCAFE_0108);
        expect_d(32'h2010, 32'hA5A5_0F0F, 4'b0011, 32'hCAFE_2010);
        d_addr = 32'h2010; d_wdata = 32'hA5A5_0F0F; d_we = 4'b0011; d_req = 1'b1;
        i_addr = 32'h108; i_req = 1'b1;
        for (int k = 0; k < 4; k++) wait_valid(1'b1, lat);
        wait_valid(1'b0, lat);
        @(posedge clk); #1;
        i_req = 1'b0;
        wait_valid(1'b1, lat);
        @(posedge clk); #1;
        d_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 4: grant stalled five cycles
        gnt_delay = 5; rsp_delay = 1;
        expect_i(32'h300, 32'hCAFE_0300);
        i_addr = 32'h300; i_req = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t4_stall {mem_req,i_valid,d_valid}", 32'({mem_req, i_valid, d_valid}), 32'h4);
            check("t4_stall_address", mem_address, 32'h300);
        end
        wait_valid(1'b0, lat);
        check("t4_remaining_latency", 32'(lat), 32'd3);
        @(posedge clk); #1;
        i_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 5: reset while waiting for the response; the late response is spurious
        gnt_delay = 0; rsp_delay = 4;
        begin
            mem_exp_t m;
            m.addr = 32'h500; m.wdata = '0; m.we = 4'h0; m.chk_wdata = 1'b0;
            mem_q.push_back(m);
        end
        i_addr = 32'h500; i_req = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(negedge clk);
                if (mem_req && mem_gnt) seen = 1'b1;
            end
            if (!seen) begin
                checks++;
                $display("FAIL t5_handshake: no grant within 20 cycles");
            end
        end
        @(posedge clk); #1;
        reset = 1'b1; i_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("t5_after_reset_err", 32'(err_spurious), 32'h0);
        check("t5_after_reset_mem_req", 32'(mem_req), 32'h0);
        repeat (6) @(negedge clk);
        check("t5_err_spurious", 32'(err_spurious), 32'h1);
        check("t5_idle_mem_req", 32'(mem_req), 32'h0);
        @(posedge clk); #1;
        rsp_delay = 2;
        expect_i(32'h504, 32'hCAFE_0504);
        i_addr = 32'h504; i_req = 1'b1;
        wait_valid(1'b0, lat);
        @(posedge clk); #1;
        i_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 6: load with grant and response in the same cycle: 2-cycle latency
        gnt_delay = 0; rsp_delay = 0;
        expect_d(32'h400, 32'h0, 4'h0, 32'h0000_00AA);
        d_addr = 32'h400; d_wdata = 32'hFFFF_FFFF; d_we = 4'h0; d_req = 1'b1;
        wait_valid(1'b1, lat);
        check("t6_latency", 32'(lat), 32'd2);
        @(posedge clk); #1;
        d_req = 1'b0;
        repeat (4) @(posedge clk);

        @(negedge clk);
        check("end_mem_q_drained", 32'(mem_q.size()), 32'h0);
        check("end_rsp_q_drained", 32'(rsp_q.size()), 32'h0);
        check("end_err_sticky", 32'(err_spurious), 32'h1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
